// File: rtl/mult_issue_queue_if.sv
// Operand/response bundle between a producer, the issue queue and the iterative multiplier.
// slave = queue side, master = producer/multiplier/consumer side.
interface mult_issue_queue_if #(
    parameter int XLEN  = 16,
    parameter int DEPTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         in_a;
    logic [XLEN-1:0]         in_b;
    logic                    mul_start;
    logic [XLEN-1:0]         mul_a;
    logic [XLEN-1:0]         mul_b;
    logic                    mul_done;
    logic [2*XLEN-1:0]       mul_product;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [2*XLEN-1:0]       rsp_product;
    logic [$clog2(DEPTH):0]  occupancy;

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_product, rsp_ready,
        output in_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_product, occupancy
    );

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_product, rsp_ready,
        input  in_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_product, occupancy
    );
endinterface

// File: rtl/mult_issue_queue.sv
// Operand FIFO in front of an iterative multiplier: issues one pair at a time,
// waits for done, returns the product; zero operands short-circuit the multiplier.
module mult_issue_queue #(
    parameter int XLEN  = 16,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mult_issue_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     a_mem [DEPTH];
    logic [XLEN-1:0]     b_mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         occ_q;
    logic [XLEN-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [2*XLEN-1:0]   rsp_prod_q, rsp_prod_d;
    logic                full, empty, push, pop;
    logic [XLEN-1:0]     head_a, head_b;

    // Full blocks pushes even if a pop happens the same cycle.
    assign full   = (occ_q == FULL_CNT);
    assign empty  = (occ_q == '0);
    assign push   = bus.in_valid && !full;
    assign pop    = (state_q == IDLE) && !empty;
    assign head_a = a_mem[rd_ptr_q];
    assign head_b = b_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q] <= bus.in_a;
            b_mem[wr_ptr_q] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + (AW+1)'(1);
                2'b01:   occ_q <= occ_q - (AW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_prod_q  <= '0;
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_prod_q  <= rsp_prod_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_prod_d  = rsp_prod_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    mul_a_d = head_a;
                    mul_b_d = head_b;
                    if (head_a == '0 || head_b == '0) begin
                        rsp_prod_d  = '0;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            // A done level left over from the previous op is ignored here.
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mul_done) begin
                    rsp_prod_d  = bus.mul_product;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready    = !full;
    assign bus.mul_start   = (state_q == ISSUE);
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_product = rsp_prod_q;
    assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_mult_issue_queue.sv
// Self-checking bench for mult_issue_queue: directed scenarios plus a randomized run,
// scored against a queue of expected products and expected multiplier issues.
module tb_mult_issue_queue;
    localparam int XLEN  = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mult_issue_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    mult_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Multiplier stand-in: product after `lat` cycles; done pulses one cycle
    // unless hold_done keeps it high until the next start.
    logic        md_q = 1'b0;
    logic [31:0] mp_q = '0;
    logic [31:0] prod_q = '0;
    int          cnt_q = 0;
    bit          busy_q = 1'b0;
    int          lat = 6;
    bit          hold_done = 1'b0;
    bit          mul_en = 1'b1;
    bit          extra_done = 1'b0;

    assign bus.mul_done    = md_q | extra_done;
    assign bus.mul_product = mp_q;

    always @(posedge clk) begin
        if (bus.mul_start) begin
            busy_q <= 1'b1;
            cnt_q  <= lat;
            prod_q <= 32'(bus.mul_a) * 32'(bus.mul_b);
            md_q   <= 1'b0;
        end else if (busy_q && cnt_q <= 1 && mul_en) begin
            busy_q <= 1'b0;
            md_q   <= 1'b1;
            mp_q   <= prod_q;
        end else begin
            if (busy_q && cnt_q > 1) cnt_q <= cnt_q - 1;
            if (!hold_done) md_q <= 1'b0;
        end
    end

    // Observed traffic (recorded only, compared inside the test tasks).
    logic [31:0] rsp_q [$];
    logic [15:0] sa_q [$];
    logic [15:0] sb_q [$];
    int          rv_cnt = 0;

    always @(negedge clk) begin
        if (bus.rsp_valid && bus.rsp_ready) rsp_q.push_back(bus.rsp_product);
        if (bus.mul_start) begin
            sa_q.push_back(bus.mul_a);
            sb_q.push_back(bus.mul_b);
        end
        if (bus.rsp_valid) rv_cnt++;
    end

    // Reference model: every accepted pair yields a*b, in order; only
    // pairs with both operands nonzero reach the multiplier.
    logic [31:0] exp_q [$];
    logic [15:0] ea_q [$];
    logic [15:0] eb_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back(32'(a) * 32'(b));
        if (a != 0 && b != 0) begin
            ea_q.push_back(a);
            eb_q.push_back(b);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a = a;
        bus.in_b = b;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL push_accept a=%0d b=%0d got in_ready never high, required accept", a, b);
        end else begin
            model_accept(a, b);
        end
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (rsp_q.size() >= n) ok = 1'b1;
            else tick();
        end
        if (ok) tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.mul_start !== 1'b0) begin failures++; $display("FAIL reset_mul_start got %b want 0", bus.mul_start); end
        checks++; if (bus.mul_a !== 16'd0 || bus.mul_b !== 16'd0) begin failures++; $display("FAIL reset_mul_ab got %h/%h want 0/0", bus.mul_a, bus.mul_b); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_product !== 32'd0) begin failures++; $display("FAIL reset_rsp_product got %h want 0", bus.rsp_product); end
        checks++; if (bus.occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int b0 = rsp_q.size();
        int s0 = sa_q.size();
        bit ok;
        bus.rsp_ready = 1'b1; lat = 6; mul_en = 1'b1; hold_done = 1'b0;
        push(16'd3, 16'd5);
        @(negedge clk);
        checks++; if (bus.occupancy !== 3'd1 || bus.mul_start !== 1'b0) begin failures++; $display("FAIL single_after_push occ=%0d start=%b want 1/0", bus.occupancy, bus.mul_start); end
        @(negedge clk);
        checks++; if (bus.occupancy !== 3'd0 || bus.mul_start !== 1'b1) begin failures++; $display("FAIL single_issue occ=%0d start=%b want 0/1", bus.occupancy, bus.mul_start); end
        checks++; if (bus.mul_a !== 16'd3 || bus.mul_b !== 16'd5) begin failures++; $display("FAIL single_operands got %0d/%0d want 3/5", bus.mul_a, bus.mul_b); end
        @(negedge clk);
        checks++; if (bus.mul_start !== 1'b0) begin failures++; $display("FAIL single_start_width got %b want 0", bus.mul_start); end
        tick();
        wait_rsp(b0 + 1, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_rsp_timeout got none want 15"); end
        else if (rsp_q[b0] !== exp_q[b0]) begin failures++; $display("FAIL single_product got %0d want %0d", rsp_q[b0], exp_q[b0]); end
        checks++; if (sa_q.size() - s0 != 1) begin failures++; $display("FAIL single_start_count got %0d want 1", sa_q.size() - s0); end
    endtask

    task automatic test_zero_bypass();
        int b0 = rsp_q.size();
        int s0 = sa_q.size();
        bit ok;
        push(16'd0, 16'd9);
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.occupancy !== 3'd1) begin failures++; $display("FAIL zero_pre_pop rv=%b occ=%0d want 0/1", bus.rsp_valid, bus.occupancy); end
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 32'd0) begin failures++; $display("FAIL zero_bypass_rsp rv=%b prod=%h want 1/0", bus.rsp_valid, bus.rsp_product); end
        tick();
        push(16'd7, 16'd0);
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_product !== 32'd0) begin failures++; $display("FAIL zero_bypass_rsp2 rv=%b prod=%h want 1/0", bus.rsp_valid, bus.rsp_product); end
        tick();
        wait_rsp(b0 + 2, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL zero_rsp_timeout got %0d want 2", rsp_q.size() - b0); end
        else if (rsp_q[b0] !== 32'd0 || rsp_q[b0+1] !== 32'd0) begin failures++; $display("FAIL zero_products got %h,%h want 0,0", rsp_q[b0], rsp_q[b0+1]); end
        checks++; if (sa_q.size() != s0) begin failures++; $display("FAIL zero_no_start got %0d starts want 0", sa_q.size() - s0); end
    endtask

    task automatic test_backpressure();
        logic [15:0] pa [6];
        logic [15:0] pb [6];
        int b0 = rsp_q.size();
        int s0 = sa_q.size();
        int acc = 0;
        bit ok;
        pa = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12};
        pb = '{16'd3, 16'd5, 16'd7, 16'd9, 16'd11, 16'd13};
        bus.rsp_ready = 1'b0; mul_en = 1'b0; lat = 2;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1; bus.in_a = pa[i]; bus.in_b = pb[i];
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            if (ok) begin acc++; model_accept(pa[i], pb[i]); end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (acc != 5) begin failures++; $display("FAIL bp_accepted got %0d want 5", acc); end
        checks++; if (bus.occupancy !== 3'd4 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_full occ=%0d in_ready=%b want 4/0", bus.occupancy, bus.in_ready); end
        checks++; if (sa_q.size() - s0 != 1) begin failures++; $display("FAIL bp_one_inflight got %0d starts want 1", sa_q.size() - s0); end
        tick();
        mul_en = 1'b1; bus.rsp_ready = 1'b1;
        wait_rsp(b0 + 5, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bp_rsp_timeout got %0d want 5", rsp_q.size() - b0); end
        else begin
            for (int i = 0; i < 5; i++)
                if (rsp_q[b0+i] !== exp_q[b0+i]) begin
                    failures++; $display("FAIL bp_order idx=%0d got %0d want %0d", i, rsp_q[b0+i], exp_q[b0+i]);
                end
        end
        checks++; if (exp_q[b0+4] !== 32'd110 || rsp_q.size() < b0 + 5 || rsp_q[b0+4] !== 32'd110) begin failures++; $display("FAIL bp_last got %0d want 110", (rsp_q.size() >= b0 + 5) ? rsp_q[b0+4] : 32'hx); end
    endtask

    task automatic test_simul_push_pop();
        int b0 = rsp_q.size();
        bit ok = 1'b0;
        bus.rsp_ready = 1'b0; mul_en = 1'b1; lat = 3;
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rsp_valid;
            if (!ok) tick();
        end
        checks++; if (!ok || bus.occupancy !== 3'd2) begin failures++; $display("FAIL simul_setup rv=%b occ=%0d want 1/2", ok, bus.occupancy); end
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 16'd7; bus.in_b = 16'd8;
        @(negedge clk);
        checks++; if (bus.occupancy !== 3'd2 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL simul_pre occ=%0d in_ready=%b want 2/1", bus.occupancy, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        model_accept(16'd7, 16'd8);
        @(negedge clk);
        checks++; if (bus.occupancy !== 3'd2) begin failures++; $display("FAIL simul_occ got %0d want 2", bus.occupancy); end
        checks++; if (bus.mul_start !== 1'b1 || bus.mul_a !== 16'd3) begin failures++; $display("FAIL simul_issue start=%b a=%0d want 1/3", bus.mul_start, bus.mul_a); end
        tick();
        bus.rsp_ready = 1'b1;
        wait_rsp(b0 + 4, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL simul_rsp_timeout got %0d want 4", rsp_q.size() - b0); end
        else begin
            for (int i = 0; i < 4; i++)
                if (rsp_q[b0+i] !== exp_q[b0+i]) begin
                    failures++; $display("FAIL simul_order idx=%0d got %0d want %0d", i, rsp_q[b0+i], exp_q[b0+i]);
                end
        end
    endtask

    task automatic test_stale_done();
        int b0 = rsp_q.size();
        bit ok;
        bus.rsp_ready = 1'b1; mul_en = 1'b1; lat = 3; hold_done = 1'b1;
        push(16'hFFFF, 16'hFFFF);
        push(16'd7, 16'd9);
        wait_rsp(b0 + 2, ok);
        hold_done = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL stale_rsp_timeout got %0d want 2", rsp_q.size() - b0); end
        else begin
            if (rsp_q[b0] !== 32'hFFFE0001) begin failures++; $display("FAIL stale_max_product got %h want fffe0001", rsp_q[b0]); end
            checks++;
            if (rsp_q[b0+1] !== exp_q[b0+1]) begin failures++; $display("FAIL stale_second got %h want %h", rsp_q[b0+1], exp_q[b0+1]); end
        end
        tick();
        @(negedge clk);
        checks++; if (bus.mul_a !== 16'd7 || bus.mul_b !== 16'd9 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL stale_hold_ab got %0d/%0d rv=%b want 7/9/0", bus.mul_a, bus.mul_b, bus.rsp_valid); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int rv0, s0;
        bus.rsp_ready = 1'b1; mul_en = 1'b1; lat = 20;
        push(16'd2, 16'd2);
        push(16'd3, 16'd3);
        push(16'd4, 16'd4);
        push(16'd5, 16'd5);
        @(negedge clk);
        checks++; if (bus.occupancy !== 3'd3 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_setup occ=%0d rv=%b want 3/0", bus.occupancy, bus.rsp_valid); end
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.mul_start !== 1'b0 || bus.mul_a !== 16'd0 || bus.mul_b !== 16'd0 ||
            bus.rsp_valid !== 1'b0 || bus.rsp_product !== 32'd0 || bus.occupancy !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs rdy=%b st=%b a=%0d b=%0d rv=%b p=%h occ=%0d want 1/0/0/0/0/0/0",
                     bus.in_ready, bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_valid, bus.rsp_product, bus.occupancy);
        end
        while (exp_q.size() > rsp_q.size()) exp_q.pop_back();
        while (ea_q.size() > sa_q.size()) begin ea_q.pop_back(); eb_q.pop_back(); end
        rv0 = rv_cnt;
        s0 = sa_q.size();
        tick();
        for (int i = 0; i < 30; i++) begin
            extra_done = (i == 3);
            tick();
        end
        extra_done = 1'b0;
        checks++; if (rv_cnt != rv0 || sa_q.size() != s0) begin failures++; $display("FAIL rst_stale_done rv_cycles=%0d starts=%0d want 0/0", rv_cnt - rv0, sa_q.size() - s0); end
    endtask

    task automatic test_random();
        localparam int N = 24;
        int b0 = rsp_q.size();
        int s0 = sa_q.size();
        int e0 = ea_q.size();
        int sent = 0;
        bit ok;
        logic [15:0] a, b;
        for (int cyc = 0; cyc < 4000 && sent < N; cyc++) begin
            a = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_a = a; bus.in_b = b;
            bus.rsp_ready = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 8);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin sent++; model_accept(a, b); end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        checks++; if (sent != N) begin failures++; $display("FAIL rand_sent got %0d want %0d", sent, N); end
        wait_rsp(b0 + sent, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rand_rsp_timeout got %0d want %0d", rsp_q.size() - b0, sent); end
        else begin
            for (int i = 0; i < sent; i++)
                if (rsp_q[b0+i] !== exp_q[b0+i]) begin
                    failures++; $display("FAIL rand_product idx=%0d got %h want %h", i, rsp_q[b0+i], exp_q[b0+i]);
                end
        end
        checks++;
        if (sa_q.size() - s0 != ea_q.size() - e0) begin
            failures++; $display("FAIL rand_start_count got %0d want %0d", sa_q.size() - s0, ea_q.size() - e0);
        end else begin
            for (int i = 0; i < ea_q.size() - e0; i++)
                if (sa_q[s0+i] !== ea_q[e0+i] || sb_q[s0+i] !== eb_q[e0+i]) begin
                    failures++; $display("FAIL rand_issue idx=%0d got %h/%h want %h/%h", i, sa_q[s0+i], sb_q[s0+i], ea_q[e0+i], eb_q[e0+i]);
                end
        end
    endtask

    initial begin
        resetn = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_zero_bypass();
        test_backpressure();
        test_simul_push_pop();
        test_stale_done();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
